uart_receiver: RTL and testbench

//  UART 8N1 serial receiver. Oversamples the asynchronous rx line with the system clock and

---
 rtl/uart_receiver.sv | 115 +++++++++++
 tb/tb_uart_receiver.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM,
// one-cycle data_valid strobe per good byte.
module uart_receiver #(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid
);

  localparam int CLKS_PER_BIT = CLK_HZ / BITRATE_BPS;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            rx_s;

  assign rx_s       = sync_q[1];
  assign data       = data_q;
  assign data_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == T_FULL) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // a line held low must not be taken as a new start bit
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: framed bytes, glitch,
// framing error, mid-frame reset and back-to-back frames.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;

  int passed = 0;
  int total  = 0;

  logic [7:0] got_q[$];
  logic       in_stop = 1'b0;
  logic       prev_v = 1'b0;
  int         wide = 0;
  int         bad_timing = 0;

  uart_receiver #(
    .CLK_HZ(1_600_000),
    .BITRATE_BPS(100_000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data(data),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data);
      if (!in_stop) bad_timing++;
      if (prev_v) wide++;
    end
    prev_v = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                            input int nstop, input int nidle);
    repeat (nidle) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    in_stop = 1'b1;
    send_bit(stop_ok);
    in_stop = 1'b0;
    repeat (nstop - 1) send_bit(1'b1);
  endtask

  task automatic expect_q(input string tag, input logic [7:0] e[6],
                          input int n);
    logic [31:0] g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
      chk($sformatf("%s_byte%0d", tag, i), g, 32'(e[i]));
    end
    got_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    got_q.delete();

    send_frame(8'h05, 1'b1, 5, 3);
    send_frame(8'h08, 1'b1, 5, 3);
    send_frame(8'h11, 1'b1, 5, 3);
    expect_q("t1", '{8'h05, 8'h08, 8'h11, 8'h00, 8'h00, 8'h00}, 3);

    send_frame(8'hA1, 1'b1, 5, 3);
    send_frame(8'hA3, 1'b1, 5, 3);
    send_frame(8'hA5, 1'b1, 5, 3);
    send_frame(8'h1A, 1'b1, 5, 3);
    send_frame(8'h2B, 1'b1, 5, 3);
    send_frame(8'h30, 1'b1, 5, 3);
    repeat (4) send_bit(1'b1);
    expect_q("t2", '{8'hA1, 8'hA3, 8'hA5, 8'h1A, 8'h2B, 8'h30}, 6);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) send_bit(1'b1);
    send_frame(8'h55, 1'b1, 5, 3);
    expect_q("t3", '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    send_frame(8'hFF, 1'b0, 5, 3);
    chk("t4_bad_count", 32'(got_q.size()), 32'd0);
    chk("t4_data_held", 32'(data), 32'h55);
    send_frame(8'h3C, 1'b1, 5, 3);
    expect_q("t4", '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    repeat (3) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    rx = 1'(8'hC3 >> 4);
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_data", 32'(data), 32'h00);
    chk("t5_rst_valid", 32'(data_valid), 32'h0);
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("t5_post_data", 32'(data), 32'h00);
    send_frame(8'h96, 1'b1, 5, 3);
    expect_q("t5", '{8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    send_frame(8'h00, 1'b1, 1, 3);
    send_frame(8'hFF, 1'b1, 1, 0);
    repeat (3) send_bit(1'b1);
    expect_q("t6", '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 2);

    chk("strobe_width", 32'(wide), 32'd0);
    chk("strobe_in_stop", 32'(bad_timing), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
